rt_mem_ctrl: RTL and testbench
==============================

# rt_mem_ctrl

Request controller for the racetrack (RT) logic-in-memory data array. It arbitrates between NUM_REQ requesters: core LSU, debug/DMA. It serializes one transaction at a time onto the RT port, and converts byte addresses plus byte enables into one-hot word lines. It holds the command stable until the memory's valid pulse, then returns one response per grant. It sits between the core data interface and the RT memory model, and owns all RT handshake sequencing, including LiM AND/OR/XOR operations.

## Interface
- ADDR_WIDTH, 10, byte-address width into the RT array
- BYTES, 1024, number of RT rows (bytes); must equal 2**ADDR_WIDTH
- NUM_REQ, 2, number of requesters
- TIMEOUT_CYCLES, 64, watchdog limit (used only with the macro)

Ports:
- clk_i  in  1  single clock
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  NUM_REQ  request valid per requester
- we_i  in  NUM_REQ  write enable per requester
- addr_i  in  NUM_REQ×ADDR_WIDTH  byte address; addr[1:0] ignored
- be_i  in  NUM_REQ×4  byte enables
- opcode_i  in  NUM_REQ×3  memory function: plain, or FUNCT_AND/OR/XOR
- mask_i  in  NUM_REQ×32  LiM operand
- wdata_i  in  NUM_REQ×32  write data
- gnt_o  out  NUM_REQ  one-hot grant, combinational
- rvalid_o  out  NUM_REQ  one-cycle response pulse to the granted requester
- rdata_o  out  32  response data
- err_o  out  1  timeout error, qualifies rvalid_o
- en_b_int_o, we_b_o  out  1  RT port enable and write enable
- word_lines_o  out  BYTES  one-hot-per-byte row select
- opcode_mem_o  out  3  RT function
- mask_o, wdata_b_o  out  32  RT operands
- rdata_b_i  in  32  RT read data
- rvalid_rt_i  in  1  RT completion pulse

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - BUSY: en_b_int_o=1, waiting for rvalid_rt_i.
  - RESP: emit the response.
- IDLE:
  - If any req_i is set, rt_rr_arbiter selects a winner and gnt_o asserts in that cycle.
  - The winner's we/addr/be/opcode/mask/wdata are latched into command registers, and the state moves to BUSY.
- Arbitration is round-robin. The pointer moves past the winner on each grant. After reset the pointer favours requester 0.
- BUSY:
  - All RT outputs come from the command registers and are stable for the whole transaction.
  - On the edge where rvalid_rt_i=1, en_b_int_o clears and the state moves to RESP. This lets the RT leave PORT_RESET to IDLE.
- RESP:
  - rvalid_o[winner]=1 for one cycle, then the state returns to IDLE.
  - For reads and LiM reads, rdata_o=rdata_b_i sampled this cycle, because RT read data is registered one cycle after its valid pulse.
  - For writes, rdata_o=0.
- Word lines: base=addr & ~3. word_lines_o[base+k]=be[k] for k=0..3; all other bits are 0. For reads, bit base is forced to 1, because the RT decodes reads from the base row.
- The controller never interprets opcode_mem_o. LiM latency is absorbed by waiting on rvalid_rt_i.
- gnt_o is 0 in BUSY and RESP. A requester holding req_i is granted in a later IDLE cycle.

## Timing
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, en_b_int_o=0, we_b_o=0, word_lines_o=0, opcode_mem_o=0, mask_o=0, wdata_b_o=0. State IDLE, arbitration pointer at 0.
- Plain access:
  - Grant at cycle 0; en_b_int_o high from cycle 1.
  - RT goes PORT_SET at 2, READ/WRITE at 3 (rvalid_rt_i=1).
  - rvalid_o at cycle 4.
- Latency in general is the cycle of rvalid_rt_i + 1.
- LiM AND/OR adds the RT programming wait. The controller's behaviour is unchanged.
- Back-to-back: the next grant can occur the cycle after RESP. Its en_b_int_o then arrives while the RT is in IDLE or PORT_RESET; both paths lead to PORT_SET.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers see no grant and are not dropped.
- Reset mid-transaction: everything returns to reset values immediately, and no response is issued. The RT shares rst_ni.

## Configuration
- RT_CTRL_TIMEOUT_EN defined:
  - A counter runs in BUSY.
  - If TIMEOUT_CYCLES elapse without rvalid_rt_i, en_b_int_o clears and the state moves to RESP.
  - RESP then asserts rvalid_o with err_o=1 and rdata_o=0.
- RT_CTRL_TIMEOUT_EN undefined: no counter, err_o tied to 0, and BUSY waits indefinitely.

## Structure
- Shared package rt_ctrl_pkg holds:
  - the controller state enum (IDLE, BUSY, RESP);
  - WORD_BYTES=4;
  - the command struct (we, addr, be, opcode, mask, wdata).
- FUNCT_* encodings are reused from riscv_defines and are not redefined.
- One sub-module, rt_rr_arbiter: NUM_REQ-way round-robin with a registered pointer, one-hot grant output, and an advance input.

## Test plan
- Word write then read:
  - Requester 0 writes addr 0x010, be=4'hF, wdata=0xDEADBEEF.
  - Word lines 16..19 are set, and rvalid_o[0] arrives 4 cycles after grant.
  - Reading 0x010 returns 0xDEADBEEF.
- Byte write: be=4'b0100, wdata=0x00AA0000 to 0x010 → word_lines_o has only bit 18 set. A following read returns 0xDEAABEEF.
- LiM read: opcode=FUNCT_AND, mask=0x0000FFFF, read 0x010 → rdata_o=0x0000BEEF. The response arrives after the RT's LiM wait, and en_b_int_o is held for the whole interval.
- Contention: both requesters request continuously → grants alternate 0,1,0,1, with exactly one rvalid_o per grant to the matching requester.
- Reset asserted while in BUSY → all outputs are 0 on the next edge, no rvalid_o follows, and a fresh request after release completes normally.
- With RT_CTRL_TIMEOUT_EN and rvalid_rt_i held at 0 → rvalid_o with err_o=1 at grant+TIMEOUT_CYCLES+2.

Source files
------------

// File: rtl/rt_ctrl_pkg.sv
// Shared types for the racetrack memory request controller.
// Holds the controller state encoding and the latched command bundle.
package rt_ctrl_pkg;

    localparam int WORD_BYTES = 4;
    localparam int RT_ADDR_W  = 10;
    localparam int RT_OP_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } ctrl_state_e;

    typedef struct packed {
        logic                  we;
        logic [RT_ADDR_W-1:0]  addr;
        logic [WORD_BYTES-1:0] be;
        logic [RT_OP_W-1:0]    opcode;
        logic [31:0]           mask;
        logic [31:0]           wdata;
    } rt_cmd_t;

endpackage

// File: rtl/rt_mem_ctrl_arb.sv
// Round-robin arbiter for the racetrack controller.
// Pointer favours requester 0 after reset and moves past each winner.
module rt_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_nxt;

    always_comb begin
        int   j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        if (int'(idx_o) == NUM_REQ - 1) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i && |req_i) begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/rt_mem_ctrl.sv
// Racetrack memory request controller: arbitrates, serializes and sequences RT handshakes.
// Optional BUSY watchdog enabled by defining RT_CTRL_TIMEOUT_EN.
module rt_mem_ctrl
    import rt_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTES          = 1024,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*4-1:0]          be_i,
    input  logic [NUM_REQ*3-1:0]          opcode_i,
    input  logic [NUM_REQ*32-1:0]         mask_i,
    input  logic [NUM_REQ*32-1:0]         wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [31:0]                   rdata_o,
    output logic                          err_o,
    output logic                          en_b_int_o,
    output logic                          we_b_o,
    output logic [BYTES-1:0]              word_lines_o,
    output logic [2:0]                    opcode_mem_o,
    output logic [31:0]                   mask_o,
    output logic [31:0]                   wdata_b_o,
    input  logic [31:0]                   rdata_b_i,
    input  logic                          rvalid_rt_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    ctrl_state_e        state_q;
    rt_cmd_t            cmd_q;
    rt_cmd_t            cmd_d;
    logic [NUM_REQ-1:0] win_q;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               en_q;
    logic [NUM_REQ-1:0] rvalid_q;
    logic               resp_err;
    logic               unused_addr;

`ifdef RT_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    rt_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .advance_i (state_q == IDLE),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx)
    );

    always_comb begin
        int w;
        w            = int'(arb_idx);
        cmd_d        = '0;
        cmd_d.we     = we_i[w];
        cmd_d.addr   = addr_i[w*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_d.be     = be_i[w*4 +: 4];
        cmd_d.opcode = opcode_i[w*3 +: 3];
        cmd_d.mask   = mask_i[w*32 +: 32];
        cmd_d.wdata  = wdata_i[w*32 +: 32];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            win_q    <= '0;
            en_q     <= 1'b0;
            rvalid_q <= '0;
`ifdef RT_CTRL_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        cmd_q   <= cmd_d;
                        win_q   <= arb_gnt;
                        en_q    <= 1'b1;
                        state_q <= BUSY;
`ifdef RT_CTRL_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (rvalid_rt_i) begin
                        en_q     <= 1'b0;
                        rvalid_q <= win_q;
                        state_q  <= RESP;
                    end
`ifdef RT_CTRL_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                        en_q     <= 1'b0;
                        rvalid_q <= win_q;
                        err_q    <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    rvalid_q <= '0;
                    cmd_q    <= '0;
                    state_q  <= IDLE;
`ifdef RT_CTRL_TIMEOUT_EN
                    err_q    <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reads always select the base row since the RT decodes reads from it
    always_comb begin
        word_lines_o = '0;
        if (state_q != IDLE) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                word_lines_o[{cmd_q.addr[ADDR_WIDTH-1:2], 2'(k)}] = cmd_q.be[k];
            end
            if (!cmd_q.we) begin
                word_lines_o[{cmd_q.addr[ADDR_WIDTH-1:2], 2'b00}] = 1'b1;
            end
        end
    end

    assign unused_addr  = ^cmd_q.addr[1:0];

    assign gnt_o        = (state_q == IDLE) ? arb_gnt : '0;
    assign rvalid_o     = rvalid_q;
    assign err_o        = resp_err;
    assign en_b_int_o   = en_q;
    assign we_b_o       = cmd_q.we;
    assign opcode_mem_o = cmd_q.opcode;
    assign mask_o       = cmd_q.mask;
    assign wdata_b_o    = cmd_q.wdata;

    // RT read data lands one cycle after its valid pulse, i.e. during RESP
    assign rdata_o = (state_q == RESP && !cmd_q.we && !resp_err) ?
                     rdata_b_i : 32'h0;

endmodule

// File: tb/tb_rt_mem_ctrl.sv
// Directed testbench for rt_mem_ctrl with a small behavioural RT memory.
// Define RT_CTRL_TIMEOUT_EN to also exercise the watchdog.
module tb_rt_mem_ctrl;

    localparam int AW = 10;
    localparam int NB = 1024;
    localparam int NR = 2;
    localparam int TO = 64;

    localparam logic [2:0] OP_PLAIN = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b110;
    localparam logic [2:0] OP_AND   = 3'b111;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req;
    logic [NR-1:0]  we;
    logic [NR*AW-1:0] addr;
    logic [NR*4-1:0]  be;
    logic [NR*3-1:0]  opcode;
    logic [NR*32-1:0] mask;
    logic [NR*32-1:0] wdata;
    logic [NR-1:0]  gnt;
    logic [NR-1:0]  rvalid;
    logic [31:0]    rdata;
    logic           err;
    logic           en;
    logic           we_b;
    logic [NB-1:0]  word_lines;
    logic [2:0]     opcode_mem;
    logic [31:0]    mask_b;
    logic [31:0]    wdata_b;
    logic [31:0]    rdata_b;
    logic           rvalid_rt;

    int n_chk  = 0;
    int n_fail = 0;
    bit hang   = 1'b0;

    always #5 clk = ~clk;

    rt_mem_ctrl #(
        .ADDR_WIDTH     (AW),
        .BYTES          (NB),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .be_i         (be),
        .opcode_i     (opcode),
        .mask_i       (mask),
        .wdata_i      (wdata),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .err_o        (err),
        .en_b_int_o   (en),
        .we_b_o       (we_b),
        .word_lines_o (word_lines),
        .opcode_mem_o (opcode_mem),
        .mask_o       (mask_b),
        .wdata_b_o    (wdata_b),
        .rdata_b_i    (rdata_b),
        .rvalid_rt_i  (rvalid_rt)
    );

    // RT model: PORT_SET one cycle after enable, access the next; AND/OR add a programming wait
    logic [7:0]  mem [NB];
    int          mcnt;
    logic        mfired;
    logic [31:0] rd_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_rt <= 1'b0;
            rdata_b   <= '0;
            mcnt      <= 0;
            mfired    <= 1'b0;
            rd_hold   <= '0;
        end else begin
            rvalid_rt <= 1'b0;
            if (rvalid_rt) rdata_b <= rd_hold;
            if (!en) begin
                mcnt   <= 0;
                mfired <= 1'b0;
            end else if (!mfired && !hang) begin
                if (mcnt == ((opcode_mem == OP_AND || opcode_mem == OP_OR) ? 4 : 1)) begin
                    int          b;
                    logic [31:0] wv;
                    rvalid_rt <= 1'b1;
                    mfired    <= 1'b1;
                    if (we_b) begin
                        for (int i = 0; i < NB; i++)
                            if (word_lines[i]) mem[i] <= wdata_b[(i%4)*8 +: 8];
                    end else begin
                        b = 0;
                        for (int i = NB - 1; i >= 0; i--)
                            if (word_lines[i]) b = i & ~3;
                        wv = {mem[b+3], mem[b+2], mem[b+1], mem[b]};
                        case (opcode_mem)
                            OP_AND:  rd_hold <= wv & mask_b;
                            OP_OR:   rd_hold <= wv | mask_b;
                            OP_XOR:  rd_hold <= wv ^ mask_b;
                            default: rd_hold <= wv;
                        endcase
                    end
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [NB-1:0] obs,
                       input logic [NB-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; returns once the response cycle is over
    task automatic txn(input int r, input logic w, input logic [AW-1:0] a,
                       input logic [3:0] b, input logic [2:0] op,
                       input logic [31:0] m, input logic [31:0] d,
                       output logic [31:0] rd, output int lat,
                       output logic [NB-1:0] wl, output int en_cyc,
                       output logic er);
        req[r] = 1'b1;
        we[r]  = w;
        addr[r*AW +: AW] = a;
        be[r*4 +: 4]     = b;
        opcode[r*3 +: 3] = op;
        mask[r*32 +: 32] = m;
        wdata[r*32 +: 32] = d;
        @(negedge clk);
        chk("grant", NB'(gnt), NB'(1 << r));
        @(posedge clk); #1;
        req[r] = 1'b0;
        lat = 0; en_cyc = 0; wl = '0; rd = '0; er = 1'b0;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            if (c == 1) wl = word_lines;
            if (rvalid != '0) begin
                lat = c;
                rd  = rdata;
                er  = err;
                chk("rvalid_target", NB'(rvalid), NB'(1 << r));
                break;
            end
            if (en) en_cyc++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    logic [31:0]   rd;
    int            lat;
    int            enc;
    logic [NB-1:0] wl;
    logic [NB-1:0] exp_wl;
    logic          er;
    int            gq[$];
    int            ng;
    int            nv;
    int            bad;
    int            seen_rv;

    initial begin
        rst_n = 1'b0;
        req = '0; we = '0; addr = '0; be = '0;
        opcode = '0; mask = '0; wdata = '0;
        #2;
        chk("rst_gnt", NB'(gnt), '0);
        chk("rst_rvalid", NB'(rvalid), '0);
        chk("rst_outs", NB'({rdata, err, en, we_b, opcode_mem}), '0);
        chk("rst_operands", NB'({mask_b, wdata_b}), '0);
        chk("rst_wl", word_lines, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full word write
        txn(0, 1'b1, 10'h010, 4'hF, OP_PLAIN, 32'h0, 32'hDEADBEEF,
            rd, lat, wl, enc, er);
        exp_wl = '0; exp_wl[19:16] = 4'hF;
        chk("wr_wl", wl, exp_wl);
        chk("wr_lat", NB'(lat), NB'(4));
        chk("wr_rdata", NB'(rd), '0);

        txn(0, 1'b0, 10'h010, 4'hF, OP_PLAIN, 32'h0, 32'h0,
            rd, lat, wl, enc, er);
        chk("rd_data", NB'(rd), NB'(32'hDEADBEEF));
        chk("rd_lat", NB'(lat), NB'(4));

        // single byte lane 2
        txn(0, 1'b1, 10'h010, 4'b0100, OP_PLAIN, 32'h0, 32'h00AA0000,
            rd, lat, wl, enc, er);
        exp_wl = '0; exp_wl[18] = 1'b1;
        chk("byte_wl", wl, exp_wl);
        txn(0, 1'b0, 10'h010, 4'hF, OP_PLAIN, 32'h0, 32'h0,
            rd, lat, wl, enc, er);
        chk("byte_rd", NB'(rd), NB'(32'hDEAABEEF));

        // LiM AND read waits out the RT programming time
        txn(0, 1'b0, 10'h010, 4'hF, OP_AND, 32'h0000FFFF, 32'h0,
            rd, lat, wl, enc, er);
        chk("lim_rd", NB'(rd), NB'(32'h0000BEEF));
        chk("lim_lat", NB'(lat), NB'(7));
        chk("lim_en_held", NB'(enc), NB'(6));

        // top row, unaligned address bits ignored
        txn(0, 1'b1, 10'h3FF, 4'hF, OP_PLAIN, 32'h0, 32'h12345678,
            rd, lat, wl, enc, er);
        exp_wl = '0; exp_wl[1023:1020] = 4'hF;
        chk("top_wl", wl, exp_wl);

        // partial read still selects the base row
        txn(0, 1'b0, 10'h013, 4'b0010, OP_PLAIN, 32'h0, 32'h0,
            rd, lat, wl, enc, er);
        exp_wl = '0; exp_wl[17:16] = 2'b11;
        chk("prd_wl", wl, exp_wl);
        chk("prd_data", NB'(rd), NB'(32'hDEAABEEF));

        // reset while BUSY
        req[0] = 1'b1; we[0] = 1'b0; addr[AW-1:0] = 10'h010; be[3:0] = 4'hF;
        opcode[2:0] = OP_PLAIN;
        @(negedge clk);
        chk("mid_gnt", NB'(gnt), NB'(1));
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", NB'({gnt, rvalid, rdata, err, en, we_b}), '0);
        chk("mid_rst_wl", word_lines, '0);
        @(posedge clk); #1;
        chk("mid_rst_edge", NB'({en, rvalid, opcode_mem, mask_b}), '0);
        rst_n = 1'b1;
        seen_rv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid != '0) seen_rv++;
        end
        chk("mid_no_resp", NB'(seen_rv), '0);
        @(posedge clk); #1;
        txn(1, 1'b0, 10'h010, 4'hF, OP_PLAIN, 32'h0, 32'h0,
            rd, lat, wl, enc, er);
        chk("post_rst_rd", NB'(rd), NB'(32'hDEAABEEF));
        chk("post_rst_lat", NB'(lat), NB'(4));

        // contention: both hold requests, pointer starts back at 0
        we = '0; addr = {10'h010, 10'h010}; be = 8'hFF;
        opcode = '0; mask = '0;
        req = 2'b11;
        ng = 0; nv = 0; bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rvalid != '0) begin
                nv++;
                if (gq.size() == 0 || rvalid != NR'(1 << gq[0]) ||
                    rdata != 32'hDEAABEEF) bad++;
                if (gq.size() != 0) void'(gq.pop_front());
            end
            if (gnt != '0 && ng < 4) begin
                if (gnt !== NR'(1 << (ng % 2))) bad++;
                gq.push_back(gnt[1] ? 1 : 0);
                ng++;
            end
            @(posedge clk); #1;
            if (ng >= 4) req = '0;
        end
        chk("cont_grants", NB'(ng), NB'(4));
        chk("cont_resps", NB'(nv), NB'(4));
        chk("cont_order", NB'(bad), '0);

`ifdef RT_CTRL_TIMEOUT_EN
        hang = 1'b1;
        txn(0, 1'b0, 10'h010, 4'hF, OP_PLAIN, 32'h0, 32'h0,
            rd, lat, wl, enc, er);
        chk("to_lat", NB'(lat), NB'(TO + 2));
        chk("to_err", NB'(er), NB'(1));
        chk("to_rdata", NB'(rd), '0);
        hang = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
